// File: rtl/bnn_filter_scheduler.sv
// bnn_filter_scheduler: time-multiplexes one binary neuron (XNOR + popcount + threshold)
// across NUM_FILTERS filters. One window is accepted, evaluated against every filter,
// one filter per clock, and the packed result vector is handed downstream.
// The per-filter weight/threshold registers are written through a small config port.
module bnn_filter_scheduler #(
  parameter  int KERNEL_LEN      = 3,
  parameter  int NUM_FILTERS     = 4,
  localparam int KERNEL_SIZE     = KERNEL_LEN * KERNEL_LEN,
  localparam int THRESHOLD_WIDTH = $clog2(KERNEL_SIZE + 1),
  localparam int FIDX_W          = $clog2(NUM_FILTERS)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cfg_we_i,
  input  logic [FIDX_W-1:0]          cfg_idx_i,
  input  logic [KERNEL_SIZE-1:0]     cfg_weight_i,
  input  logic [THRESHOLD_WIDTH-1:0] cfg_threshold_i,
  output logic                       cfg_ready_o,
  input  logic                       win_valid_i,
  input  logic [KERNEL_SIZE-1:0]     win_data_i,
  output logic                       win_ready_o,
  output logic                       out_valid_o,
  output logic [NUM_FILTERS-1:0]     out_data_o,
  input  logic                       out_ready_i,
  output logic                       busy_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                     state_q, state_d;
  logic [FIDX_W-1:0]          idx_q, idx_d;
  logic [KERNEL_SIZE-1:0]     win_q;
  logic [NUM_FILTERS-1:0]     out_data_q;

  // Register file: reset value makes every filter output 0 until configured
  // (all-ones threshold exceeds the largest possible popcount).
  logic [KERNEL_SIZE-1:0]     weight_q    [NUM_FILTERS];
  logic [THRESHOLD_WIDTH-1:0] threshold_q [NUM_FILTERS];

  logic                       cfg_wr;
  logic [KERNEL_SIZE-1:0]     match_bits;
  logic [THRESHOLD_WIDTH-1:0] popcnt;
  logic                       neuron_out;

  // Handshake outputs decode straight from the registered state.
  assign win_ready_o = (state_q == IDLE);
  assign cfg_ready_o = (state_q == IDLE);
  assign out_valid_o = (state_q == DONE);
  assign busy_o      = (state_q != IDLE);
  assign out_data_o  = out_data_q;

  // Writes only land while idle so a window under evaluation never sees a mix of
  // old and new filter values; out-of-range slots are dropped.
  assign cfg_wr = cfg_we_i && cfg_ready_o && (int'(cfg_idx_i) < NUM_FILTERS);

  // Shared neuron: XNOR the latched window with the current filter, count agreements,
  // compare unsigned against that filter's threshold.
  always_comb begin
    match_bits = ~(win_q ^ weight_q[idx_q]);
    popcnt     = '0;
    for (int i = 0; i < KERNEL_SIZE; i++) begin
      popcnt = popcnt + THRESHOLD_WIDTH'(match_bits[i]);
    end
    neuron_out = (popcnt >= threshold_q[idx_q]);
  end

  // One register slot per filter, each loaded when the config port addresses it.
  for (genvar gi = 0; gi < NUM_FILTERS; gi++) begin : g_regfile
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        weight_q[gi]    <= '0;
        threshold_q[gi] <= '1;
      end else if (cfg_wr && (cfg_idx_i == FIDX_W'(gi))) begin
        weight_q[gi]    <= cfg_weight_i;
        threshold_q[gi] <= cfg_threshold_i;
      end
    end
  end

  // State and filter index registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Next-state logic: accept in IDLE, walk all filters in RUN, hold result in DONE.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (win_valid_i) begin
          state_d = RUN;
          idx_d   = '0;
        end
      end
      RUN: begin
        if (idx_q == FIDX_W'(NUM_FILTERS - 1)) begin
          idx_d   = '0;
          state_d = DONE;
        end else begin
          idx_d = idx_q + FIDX_W'(1);
        end
      end
      DONE: begin
        if (out_ready_i) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // Window latch and result accumulation; the result register is untouched in DONE,
  // which keeps out_data stable while the consumer stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_q      <= '0;
      out_data_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (win_valid_i) begin
            win_q      <= win_data_i;
            out_data_q <= '0;
          end
        end
        RUN: out_data_q[idx_q] <= neuron_out;
        default: ;
      endcase
    end
  end

endmodule
